clk_divider_prog: RTL

//  Multi-channel programmable clock-enable/divider generator. Successor to the fixed

---
 rtl/clk_divider_prog.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider: each channel emits a clock of period P
// with H cycles high, plus a start-of-period tick. New configs take effect only at period boundaries.
module clk_div_ch #(
  parameter int unsigned      CNT_W = 32,
  parameter logic [CNT_W-1:0] DEF_P = CNT_W'(4),
  parameter logic [CNT_W-1:0] DEF_H = CNT_W'(2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  output logic             pending,
  output logic             clk_div,
  output logic             tick
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt, act_p, act_h, shd_p, shd_h;
  logic             wrap, start;

  assign wrap  = (st == RUN) && (cnt == act_p - 1'b1);
  // A period starts on IDLE->RUN or on a wrap that keeps running.
  assign start = en && ((st == IDLE) || wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      act_p   <= DEF_P;
      act_h   <= DEF_H;
      shd_p   <= DEF_P;
      shd_h   <= DEF_H;
      pending <= 1'b0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      // A write landing on a boundary stays pending; the boundary uses the older shadow.
      if (wr) begin
        shd_p   <= wr_period;
        shd_h   <= wr_high;
        pending <= 1'b1;
      end else if (start) begin
        pending <= 1'b0;
      end
      if (start && pending) begin
        act_p <= shd_p;
        act_h <= shd_h;
      end
      case (st)
        IDLE: begin
          cnt     <= '0;
          clk_div <= 1'b0;
          if (en) begin
            st      <= RUN;
            clk_div <= 1'b1;
            tick    <= 1'b1;
          end
        end
        RUN: begin
          if (wrap) begin
            cnt <= '0;
            if (en) begin
              clk_div <= 1'b1;
              tick    <= 1'b1;
            end else begin
              st      <= IDLE;
              clk_div <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == act_h - 1'b1) clk_div <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

module clk_divider_prog #(
  parameter int          NUM_CH     = 2,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = 400000000,
  parameter int unsigned DEF_HIGH   = 200000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick
);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

  logic cfg_ok;

  assign cfg_ok = ({1'b0, cfg_ch} < 5'(NUM_CH)) &&
                  (cfg_period >= CNT_W'(2)) &&
                  (cfg_high != '0) && (cfg_high < cfg_period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && !cfg_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W), .DEF_P(DEF_P), .DEF_H(DEF_H)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .wr       (cfg_we && cfg_ok && (cfg_ch == 4'(i))),
      .wr_period(cfg_period),
      .wr_high  (cfg_high),
      .pending  (pending[i]),
      .clk_div  (clk_div[i]),
      .tick     (tick[i])
    );
  end
endmodule
